// File: rtl/iomem_gpio_pkg.sv
// Shared constants for the iomem GPIO peripheral: register indices (addr[4:2])
// and the default iomem window.
package iomem_gpio_pkg;
  localparam int REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] REG_OUT      = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_DIR      = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_IN       = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_OUT_SET  = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_OUT_CLR  = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_RISE_EN  = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_FALL_EN  = 3'd6;
  localparam logic [REG_IDX_W-1:0] REG_IRQ_STAT = 3'd7;

  localparam logic [7:0] GPIO_BASE_ADDR = 8'h03;
endpackage

// File: rtl/iomem_gpio_sync.sv
// WIDTH-wide two-flop synchroniser for the asynchronous GPIO pin inputs.
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_16mhz,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_s1, r_s2;

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/iomem_gpio.sv
// PicoSoC iomem GPIO: OUT/DIR/IN, atomic set/clear, optional edge interrupts.
// Define IOMEM_GPIO_IRQ_EN to build RISE_EN/FALL_EN/IRQ_STAT and the irq output.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter logic [7:0] BASE_ADDR = GPIO_BASE_ADDR
) (
  input  logic             clk_16mhz,
  input  logic             resetn,
  input  logic             i_iomem_valid,
  output logic             o_iomem_ready,
  input  logic [3:0]       i_iomem_wstrb,
  input  logic [31:0]      i_iomem_addr,
  input  logic [31:0]      i_iomem_wdata,
  output logic [31:0]      o_iomem_rdata,
  input  logic [WIDTH-1:0] i_gpio_i,
  output logic [WIDTH-1:0] o_gpio_o,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);
  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic [WIDTH-1:0]     r_out, r_dir;
  logic [WIDTH-1:0]     w_in, w_wm, w_wd, w_rd;
  logic [WIDTH-1:0]     w_rise_en, w_fall_en, w_stat;
  logic [31:0]          w_bmask;
  logic [REG_IDX_W-1:0] w_idx;
  logic                 w_sel, w_wr, w_unused;

  // The !r_ready term guarantees exactly one ack per request even if valid is held.
  assign w_sel   = i_iomem_valid && !r_ready && (i_iomem_addr[31:24] == BASE_ADDR);
  assign w_wr    = w_sel && (i_iomem_wstrb != 4'b0000);
  assign w_idx   = i_iomem_addr[4:2];
  assign w_bmask = {{8{i_iomem_wstrb[3]}}, {8{i_iomem_wstrb[2]}},
                    {8{i_iomem_wstrb[1]}}, {8{i_iomem_wstrb[0]}}};
  assign w_wm    = w_bmask[WIDTH-1:0];
  assign w_wd    = i_iomem_wdata[WIDTH-1:0] & w_wm;
  assign w_unused = ^{i_iomem_addr[23:5], i_iomem_addr[1:0], i_iomem_wdata, w_bmask};

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk_16mhz (clk_16mhz),
    .resetn    (resetn),
    .i_d       (i_gpio_i),
    .o_q       (w_in)
  );

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      r_out <= '0;
      r_dir <= '0;
    end else if (w_wr) begin
      case (w_idx)
        REG_OUT:     r_out <= (r_out & ~w_wm) | w_wd;
        REG_DIR:     r_dir <= (r_dir & ~w_wm) | w_wd;
        REG_OUT_SET: r_out <= r_out | w_wd;
        REG_OUT_CLR: r_out <= r_out & ~w_wd;
        default:     ;
      endcase
    end
  end

`ifdef IOMEM_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_rise_en, r_fall_en, r_stat, r_prev, w_ev, w_w1c;
  logic             r_irq;

  assign w_ev  = (w_in & ~r_prev & r_rise_en) | (~w_in & r_prev & r_fall_en);
  assign w_w1c = (w_wr && (w_idx == REG_IRQ_STAT)) ? w_wd : '0;

  // Clear is applied before set so a same-cycle edge keeps its STAT bit.
  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_stat    <= '0;
      r_prev    <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_prev <= w_in;
      r_stat <= (r_stat & ~w_w1c) | w_ev;
      r_irq  <= |r_stat;
      if (w_wr && (w_idx == REG_RISE_EN)) r_rise_en <= (r_rise_en & ~w_wm) | w_wd;
      if (w_wr && (w_idx == REG_FALL_EN)) r_fall_en <= (r_fall_en & ~w_wm) | w_wd;
    end
  end

  assign w_rise_en = r_rise_en;
  assign w_fall_en = r_fall_en;
  assign w_stat    = r_stat;
  assign o_irq     = r_irq;
`else
  assign w_rise_en = '0;
  assign w_fall_en = '0;
  assign w_stat    = '0;
  assign o_irq     = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (w_idx)
      REG_OUT:      w_rd = r_out;
      REG_DIR:      w_rd = r_dir;
      REG_IN:       w_rd = w_in;
      REG_RISE_EN:  w_rd = w_rise_en;
      REG_FALL_EN:  w_rd = w_fall_en;
      REG_IRQ_STAT: w_rd = w_stat;
      default:      w_rd = '0;
    endcase
  end

  always_ff @(posedge clk_16mhz) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ready <= w_sel;
      r_rdata <= w_sel ? 32'(w_rd) : 32'h0;
    end
  end

  assign o_iomem_ready = r_ready;
  assign o_iomem_rdata = r_rdata;
  assign o_gpio_o      = r_out;
  assign o_gpio_oe     = r_dir;
endmodule

// File: tb/tb_iomem_gpio.sv
// Bench for iomem_gpio (WIDTH=8): register-array model checked every cycle,
// plus directed transactions with literal expectations.
module tb_iomem_gpio;
`ifdef IOMEM_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] A_OUT  = 32'h0300_0000, A_DIR  = 32'h0300_0004,
                          A_IN   = 32'h0300_0008, A_SET  = 32'h0300_000C,
                          A_CLR  = 32'h0300_0010, A_RISE = 32'h0300_0014,
                          A_FALL = 32'h0300_0018, A_STAT = 32'h0300_001C;

  logic        clk_16mhz = 1'b0, resetn = 1'b0, valid = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [7:0]  gpio_i = 8'h0;
  logic        ready, irq;
  logic [31:0] rdata;
  logic [7:0]  gpio_o, gpio_oe;
  int checks = 0, failures = 0;

  iomem_gpio #(.WIDTH(8), .BASE_ADDR(8'h03)) dut (
    .clk_16mhz(clk_16mhz), .resetn(resetn),
    .i_iomem_valid(valid), .o_iomem_ready(ready), .i_iomem_wstrb(wstrb),
    .i_iomem_addr(addr), .i_iomem_wdata(wdata), .o_iomem_rdata(rdata),
    .i_gpio_i(gpio_i), .o_gpio_o(gpio_o), .o_gpio_oe(gpio_oe), .o_irq(irq)
  );

  always #5 clk_16mhz = ~clk_16mhz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_reg indexed by register number; hist[k] = pin sample k+1 edges ago.
  logic [7:0]  m_reg [8];
  logic [7:0]  hist [3];
  logic [7:0]  in_now, prev_now, ev, wm, wd, w1c;
  logic [31:0] m_rdata = 32'h0;
  logic [2:0]  idx;
  bit          m_ready = 0, m_rd = 0, m_irq = 0, m_irq_next, sel, started = 0;

  always @(posedge clk_16mhz) begin
    started = 1'b1;
    if (!resetn) begin
      foreach (m_reg[i]) m_reg[i] = 8'h0;
      foreach (hist[i]) hist[i] = 8'h0;
      m_ready = 0; m_rd = 0; m_irq = 0; m_rdata = 32'h0;
    end else begin
      in_now = hist[1];
      prev_now = hist[2];
      ev = IRQ_EN ? ((in_now & ~prev_now & m_reg[5]) | (~in_now & prev_now & m_reg[6])) : 8'h0;
      w1c = 8'h0;
      m_irq_next = (m_reg[7] != 8'h0);
      sel = valid && !m_ready && (addr[31:24] == 8'h03);
      if (sel) begin
        idx = addr[4:2];
        wm = wstrb[0] ? 8'hFF : 8'h00;
        wd = wdata[7:0] & wm;
        m_rd = (wstrb == 4'h0);
        case (idx)
          3'd2:       m_rdata = {24'h0, in_now};
          3'd3, 3'd4: m_rdata = 32'h0;
          default:    m_rdata = {24'h0, m_reg[idx]};
        endcase
        if (!m_rd) begin
          case (idx)
            3'd0, 3'd1: m_reg[idx] = (m_reg[idx] & ~wm) | wd;
            3'd3:       m_reg[0] = m_reg[0] | wd;
            3'd4:       m_reg[0] = m_reg[0] & ~wd;
            3'd5, 3'd6: if (IRQ_EN) m_reg[idx] = (m_reg[idx] & ~wm) | wd;
            3'd7:       w1c = wd;
            default:    ;
          endcase
        end
      end
      m_reg[7] = (m_reg[7] & ~w1c) | ev;
      m_irq = m_irq_next;
      m_ready = sel;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = gpio_i;
    end
  end

  always @(negedge clk_16mhz) begin
    if (started) begin
      chk("ready", 32'(ready), 32'(m_ready));
      if (m_ready && m_rd) chk("rdata", rdata, m_rdata);
      chk("gpio_o", 32'(gpio_o), 32'(m_reg[0]));
      chk("gpio_oe", 32'(gpio_oe), 32'(m_reg[1]));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  // Called at a negedge; returns at the negedge where ready is seen.
  task automatic xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r);
    bit got = 0;
    valid = 1'b1; addr = a; wstrb = s; wdata = d; r = 32'h0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_16mhz);
      if (ready) begin got = 1; r = rdata; end
    end
    valid = 1'b0; wstrb = 4'h0;
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  logic [31:0] r;
  logic [31:0] exp4;

  initial begin
    exp4 = IRQ_EN ? 32'h04 : 32'h00;
    repeat (3) @(negedge clk_16mhz);
    chk("rst_gpio_o", 32'(gpio_o), 32'h0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk_16mhz);
    for (int i = 0; i < 8; i++) begin
      xfer(A_OUT + 32'(4 * i), 4'h0, 32'h0, r);
      chk("rst_read", r, 32'h0);
    end

    xfer(A_OUT, 4'b0001, 32'h1A5, r);   xfer(A_OUT, 4'h0, 0, r); chk("out_a5", r, 32'hA5);
    xfer(A_SET, 4'hF, 32'h0F, r);       xfer(A_OUT, 4'h0, 0, r); chk("set_af", r, 32'hAF);
    xfer(A_CLR, 4'hF, 32'hA0, r);       xfer(A_OUT, 4'h0, 0, r); chk("clr_0f", r, 32'h0F);
    xfer(A_SET, 4'b0010, 32'hFF, r);    xfer(A_OUT, 4'h0, 0, r); chk("set_nostrb", r, 32'h0F);
    xfer(A_OUT, 4'hF, 32'hFFFF_FFFF, r); xfer(A_OUT, 4'h0, 0, r); chk("out_width", r, 32'hFF);
    xfer(A_DIR, 4'hF, 32'h3C, r);       chk("dir_oe", 32'(gpio_oe), 32'h3C);
    xfer(32'h03AB_CDE4, 4'h0, 0, r);    chk("dir_alias", r, 32'h3C);

    // valid held three cycles: ready 0,1,0
    @(negedge clk_16mhz);
    valid = 1'b1; addr = A_DIR; wstrb = 4'h0;
    #1 chk("hold_r0", 32'(ready), 32'd0);
    @(negedge clk_16mhz); chk("hold_r1", 32'(ready), 32'd1); chk("hold_data", rdata, 32'h3C);
    @(negedge clk_16mhz); chk("hold_r2", 32'(ready), 32'd0);
    valid = 1'b0;
    @(negedge clk_16mhz);

    gpio_i = 8'hA5; repeat (3) @(negedge clk_16mhz);
    xfer(A_IN, 4'h0, 0, r); chk("in_a5", r, 32'hA5);
    gpio_i = 8'h00; repeat (4) @(negedge clk_16mhz);

    // rising edge on pin 2: irq 4 cycles after the pin change
    xfer(A_RISE, 4'hF, 32'h04, r);
    xfer(A_FALL, 4'hF, 32'h00, r);
    gpio_i = 8'h04;
    repeat (3) @(negedge clk_16mhz); chk("irq_c3", 32'(irq), 32'd0);
    @(negedge clk_16mhz);            chk("irq_c4", 32'(irq), exp4 >> 2);
    xfer(A_IN, 4'h0, 0, r);   chk("in_04", r, 32'h04);
    xfer(A_STAT, 4'h0, 0, r); chk("stat_rise", r, exp4);
    xfer(A_STAT, 4'hF, 32'h04, r); chk("irq_at_w1c", 32'(irq), exp4 >> 2);
    @(negedge clk_16mhz);          chk("irq_cleared", 32'(irq), 32'd0);
    xfer(A_STAT, 4'h0, 0, r); chk("stat_w1c", r, 32'h0);

    // edge reaches STAT on the same edge as its W1C
    gpio_i = 8'h00; repeat (4) @(negedge clk_16mhz);
    gpio_i = 8'h04; repeat (2) @(negedge clk_16mhz);
    xfer(A_STAT, 4'hF, 32'h04, r);
    xfer(A_STAT, 4'h0, 0, r); chk("stat_set_wins", r, exp4);
    xfer(A_STAT, 4'hF, 32'h04, r);
    xfer(A_STAT, 4'h0, 0, r); chk("stat_clr2", r, 32'h0);

    // FALL_EN only
    xfer(A_RISE, 4'hF, 32'h00, r);
    xfer(A_FALL, 4'hF, 32'h04, r);
    xfer(A_FALL, 4'h0, 0, r); chk("fall_en_rd", r, exp4);
    gpio_i = 8'h00; repeat (5) @(negedge clk_16mhz);
    xfer(A_STAT, 4'h0, 0, r); chk("stat_fall", r, exp4);
    xfer(A_STAT, 4'hF, 32'hFF, r);
    gpio_i = 8'h04; repeat (5) @(negedge clk_16mhz);
    xfer(A_STAT, 4'h0, 0, r); chk("stat_rise_ign", r, 32'h0);

    // other window: no ack, no effect
    valid = 1'b1; addr = 32'h0200_0000; wstrb = 4'hF; wdata = 32'h0;
    repeat (3) begin
      @(negedge clk_16mhz); chk("unsel_ready", 32'(ready), 32'd0);
    end
    valid = 1'b0; wstrb = 4'h0;
    xfer(A_OUT, 4'h0, 0, r); chk("unsel_out", r, 32'hFF);

    // reset during an access
    @(negedge clk_16mhz);
    valid = 1'b1; addr = A_OUT; wstrb = 4'hF; wdata = 32'h55; resetn = 1'b0;
    @(negedge clk_16mhz);
    chk("rstmid_ready", 32'(ready), 32'd0);
    chk("rstmid_out", 32'(gpio_o), 32'h0);
    chk("rstmid_oe", 32'(gpio_oe), 32'h0);
    resetn = 1'b1; valid = 1'b0; wstrb = 4'h0;
    @(negedge clk_16mhz);
    xfer(A_OUT, 4'h0, 0, r);  chk("rstmid_rd_out", r, 32'h0);
    xfer(A_DIR, 4'h0, 0, r);  chk("rstmid_rd_dir", r, 32'h0);
    xfer(A_RISE, 4'h0, 0, r); chk("rstmid_rd_rise", r, 32'h0);
    repeat (2) @(negedge clk_16mhz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
